avmm_rr_arbiter: RTL and testbench
==================================

AVMM_RR_ARBITER -- requirements
Module: avmm_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_HOST, default 2, meaning the number of AVMM requesters sharing one sink (range 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the data width; BE_W = DATA_W/8.
REQ-003 The block SHALL have parameter ADDR_W, default 16, meaning the address width.
REQ-004 The block SHALL have parameter BURST_W, default 1, meaning the burstcount width; burstcount is passed through, and only single-beat transfers are supported.
REQ-005 The block SHALL have parameter MAX_OUT, default 8, meaning the maximum outstanding reads and, separately, the maximum outstanding writes (power of 2).
REQ-006 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; one clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- h_write, h_read  in  NUM_HOST  per-host command strobes.
- h_address  in  NUM_HOST*ADDR_W  per-host address, packed with host 0 at the LSBs (same packing for all h_* vectors).
- h_writedata  in  NUM_HOST*DATA_W  per-host write data.
- h_burstcount  in  NUM_HOST*BURST_W  per-host burstcount.
- h_byteenable  in  NUM_HOST*BE_W  per-host byte enables.
- h_waitrequest  out  NUM_HOST  per-host stall.
- h_readdatavalid, h_writeresponsevalid  out  NUM_HOST  per-host responses.
- h_readdata  out  DATA_W  shared read data, broadcast to all hosts.
- d_write, d_read  out  1  sink command strobes.
- d_address, d_writedata, d_burstcount, d_byteenable  out  widths per parameters  sink command fields.
- d_waitrequest, d_readdatavalid, d_writeresponsevalid  in  1  sink handshake and response inputs.
- d_readdata  in  DATA_W  sink read data.
- err_orphan  out  1  sticky flag for a response that arrived with no matching outstanding tag.

Function
REQ-007 The arbiter SHALL be a two-state FSM with states IDLE and BUSY, and SHALL reset to IDLE.
REQ-008 IDLE transition: if any h_read or h_write bit is set, the FSM SHALL select the lowest index at or after rr_ptr (wrapping modulo NUM_HOST), register it as gnt, and enter BUSY on the next edge.
REQ-009 IDLE with no request: the FSM SHALL stay in IDLE.
REQ-010 In BUSY, the d_* command outputs SHALL equal the fields of host gnt.
REQ-011 When the granted host has both write and read set, the block SHALL issue a write only (d_read=0).
REQ-012 In BUSY, the command SHALL be accepted in a cycle where d_write or d_read is 1 and d_waitrequest=0. On acceptance the FSM SHALL go to IDLE and set rr_ptr=(gnt+1) mod NUM_HOST.
REQ-013 Each command SHALL occupy at least 2 cycles (IDLE to BUSY); there is no back-to-back grant.
REQ-014 h_waitrequest[i] SHALL be 1 except in BUSY for i==gnt, where it SHALL equal d_waitrequest OR stall.
REQ-015 stall SHALL be 1 when the command is a read and rd_cnt==MAX_OUT, or a write and wr_cnt==MAX_OUT. While stall=1, d_read and d_write SHALL both be 0.
REQ-016 Full checks SHALL use the registered count; a same-cycle pop SHALL NOT unblock the push.
REQ-017 On each accepted read, gnt SHALL be pushed into a read tag FIFO (depth MAX_OUT). On each accepted write, gnt SHALL be pushed into a separate write tag FIFO.
REQ-018 When d_readdatavalid=1 and the read FIFO is non-empty, the block SHALL combinationally assert h_readdatavalid[head] only, drive h_readdata=d_readdata, and pop the FIFO. Writeresponses SHALL be routed the same way through the write FIFO.
REQ-019 A simultaneous push and pop on one FIFO SHALL leave its count unchanged and preserve order.
REQ-020 A response arriving while its FIFO is empty SHALL assert no h_*valid bit and SHALL set err_orphan=1 from the next cycle until reset.
REQ-021 A host deasserting its request while in BUSY is a protocol violation; the grant SHALL still be held until acceptance.

Reset
REQ-022 On rst_n=0, asynchronously: FSM=IDLE, gnt=0, rr_ptr=0, both FIFOs empty (counts 0), err_orphan=0.
REQ-023 During reset, outputs SHALL be h_waitrequest=all ones, h_readdatavalid=0, h_writeresponsevalid=0, and d_write=d_read=0.
REQ-024 Reset mid-operation SHALL discard all outstanding tags; responses arriving afterwards are orphans per REQ-020.

Verification
REQ-025 Both hosts write continuously with d_waitrequest=0 -> grants alternate 0,1,0,1, with one d_write every 2 cycles.
REQ-026 Host 1 reads A=0x10 while d_waitrequest=1 for 3 cycles -> h_waitrequest[1]=1 for those 3 cycles, d_read is held with stable d_address=0x10, and acceptance occurs on cycle 4.
REQ-027 Host0 issues 2 reads, then host1 issues 1 read; the sink returns data 0xA,0xB,0xC -> h_readdatavalid pulses go to 0,0,1 with matching data.
REQ-028 MAX_OUT=8 reads are outstanding and a 9th read is requested -> d_read=0 and h_waitrequest=1 until a readdatavalid has been popped, after which the 9th read issues.
REQ-029 d_readdatavalid=1 with nothing outstanding -> no host valid is asserted, and err_orphan=1 on the next cycle and stays set.
REQ-030 rst_n is pulsed low with 3 reads outstanding -> counts become 0 and h_waitrequest=all ones; a later d_readdatavalid sets err_orphan.

Source files
------------

// File: rtl/avmm_rr_arbiter.sv
// Round-robin arbiter that lets NUM_HOST Avalon-MM hosts share one sink. Each host's
// command is tagged in a read or write FIFO so responses can be routed back to it.
module avmm_rr_arbiter #(
  parameter  int NUM_HOST = 2,
  parameter  int DATA_W   = 64,
  parameter  int ADDR_W   = 16,
  parameter  int BURST_W  = 1,
  parameter  int MAX_OUT  = 8,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_HOST-1:0]           h_write,
  input  logic [NUM_HOST-1:0]           h_read,
  input  logic [NUM_HOST*ADDR_W-1:0]    h_address,
  input  logic [NUM_HOST*DATA_W-1:0]    h_writedata,
  input  logic [NUM_HOST*BURST_W-1:0]   h_burstcount,
  input  logic [NUM_HOST*BE_W-1:0]      h_byteenable,
  output logic [NUM_HOST-1:0]           h_waitrequest,
  output logic [NUM_HOST-1:0]           h_readdatavalid,
  output logic [NUM_HOST-1:0]           h_writeresponsevalid,
  output logic [DATA_W-1:0]             h_readdata,
  output logic                          d_write,
  output logic                          d_read,
  output logic [ADDR_W-1:0]             d_address,
  output logic [DATA_W-1:0]             d_writedata,
  output logic [BURST_W-1:0]            d_burstcount,
  output logic [BE_W-1:0]               d_byteenable,
  input  logic                          d_waitrequest,
  input  logic                          d_readdatavalid,
  input  logic                          d_writeresponsevalid,
  input  logic [DATA_W-1:0]             d_readdata,
  output logic                          err_orphan
);

  localparam int GW = $clog2(NUM_HOST);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            err_orphan_q, err_orphan_d;

  // Index 0 is the read tag FIFO, index 1 the write tag FIFO.
  logic [GW-1:0]   tag_mem_q [0:1][0:MAX_OUT-1];
  logic [PW-1:0]   wr_ptr_q  [0:1];
  logic [PW-1:0]   rd_ptr_q  [0:1];
  logic [CW-1:0]   cnt_q     [0:1];

  logic [NUM_HOST-1:0] req_s;
  logic [GW-1:0]       pick_s;
  logic [GW-1:0]       gnt_next_s;
  logic                busy_s, cmd_wr_s, cmd_rd_s, stall_s, accept_s;
  logic [1:0]          push_s, rsp_s, empty_s, full_s, pop_s;
  logic                orphan_s;
  logic [GW-1:0]       rd_head_s, wr_head_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: scan downwards so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    req_s  = h_write | h_read;
    pick_s = rr_ptr_q;
    for (int k = NUM_HOST - 1; k >= 0; k--) begin
      idx    = int'(rr_ptr_q) + k;
      idx    = (idx >= NUM_HOST) ? idx - NUM_HOST : idx;
      pick_s = req_s[idx] ? GW'(idx) : pick_s;
    end
    gnt_next_s = (gnt_q == GW'(NUM_HOST - 1)) ? '0 : gnt_q + GW'(1);
  end

  // Sink command path: fields of the granted host, write wins over read, gated by stall.
  always_comb begin
    busy_s       = (state_q == BUSY);
    cmd_wr_s     = h_write[gnt_q];
    cmd_rd_s     = h_read[gnt_q] & ~cmd_wr_s;
    stall_s      = (cmd_rd_s & full_s[0]) | (cmd_wr_s & full_s[1]);
    d_write      = busy_s & cmd_wr_s & ~stall_s;
    d_read       = busy_s & cmd_rd_s & ~stall_s;
    accept_s     = (d_write | d_read) & ~d_waitrequest;
    d_address    = h_address[int'(gnt_q)*ADDR_W +: ADDR_W];
    d_writedata  = h_writedata[int'(gnt_q)*DATA_W +: DATA_W];
    d_burstcount = h_burstcount[int'(gnt_q)*BURST_W +: BURST_W];
    d_byteenable = h_byteenable[int'(gnt_q)*BE_W +: BE_W];
  end

  // Per-host stall: only the granted host in BUSY sees the sink handshake.
  always_comb begin
    h_waitrequest = '1;
    if (busy_s) begin
      h_waitrequest[gnt_q] = d_waitrequest | stall_s;
    end else begin
      h_waitrequest = '1;
    end
  end

  // FSM next state; grant is held through BUSY even if the host drops its request.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|req_s) begin
          state_d = BUSY;
          gnt_d   = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (accept_s) begin
          state_d  = IDLE;
          rr_ptr_d = gnt_next_s;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO status, response routing and orphan detection; full uses registered counts only.
  always_comb begin
    push_s    = {accept_s & d_write, accept_s & d_read};
    rsp_s     = {d_writeresponsevalid, d_readdatavalid};
    empty_s   = {cnt_q[1] == '0, cnt_q[0] == '0};
    full_s    = {cnt_q[1] == CW'(MAX_OUT), cnt_q[0] == CW'(MAX_OUT)};
    pop_s     = rsp_s & ~empty_s;
    orphan_s  = |(rsp_s & empty_s);
    rd_head_s = tag_mem_q[0][rd_ptr_q[0]];
    wr_head_s = tag_mem_q[1][rd_ptr_q[1]];
    h_readdatavalid      = '0;
    h_writeresponsevalid = '0;
    if (pop_s[0]) begin
      h_readdatavalid[rd_head_s] = 1'b1;
    end else begin
      h_readdatavalid = '0;
    end
    if (pop_s[1]) begin
      h_writeresponsevalid[wr_head_s] = 1'b1;
    end else begin
      h_writeresponsevalid = '0;
    end
    h_readdata   = d_readdata;
    err_orphan_d = err_orphan_q | orphan_s;
    err_orphan   = err_orphan_q;
  end

  // FSM, grant, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Read and write tag FIFOs; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < 2; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        cnt_q[f]    <= '0;
        for (int i = 0; i < MAX_OUT; i++) begin
          tag_mem_q[f][i] <= '0;
        end
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (push_s[f]) begin
          tag_mem_q[f][wr_ptr_q[f]] <= gnt_q;
          wr_ptr_q[f]               <= ptr_inc(wr_ptr_q[f]);
        end
        if (pop_s[f]) begin
          rd_ptr_q[f] <= ptr_inc(rd_ptr_q[f]);
        end
        case ({push_s[f], pop_s[f]})
          2'b10:   cnt_q[f] <= cnt_q[f] + CW'(1);
          2'b01:   cnt_q[f] <= cnt_q[f] - CW'(1);
          default: cnt_q[f] <= cnt_q[f];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Scoreboard bench for avmm_rr_arbiter: directed host/sink stimulus pushes expected
// commands and responses; a negedge monitor pops and compares them.
module tb_avmm_rr_arbiter;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] data;
  } cmd_t;

  typedef struct {
    logic [1:0]  vec;
    logic [63:0] data;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   h_write, h_read;
  logic [31:0]  h_address;
  logic [127:0] h_writedata;
  logic [1:0]   h_burstcount;
  logic [15:0]  h_byteenable;
  logic [1:0]   h_waitrequest, h_readdatavalid, h_writeresponsevalid;
  logic [63:0]  h_readdata;
  logic         d_write, d_read;
  logic [15:0]  d_address;
  logic [63:0]  d_writedata;
  logic [0:0]   d_burstcount;
  logic [7:0]   d_byteenable;
  logic         d_waitrequest, d_readdatavalid, d_writeresponsevalid;
  logic [63:0]  d_readdata;
  logic         err_orphan;

  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  int   issue_cnt = 0;
  int   resp_cnt = 0;
  cmd_t exp_cmd[$];
  rsp_t exp_rrsp[$];
  rsp_t exp_wrsp[$];

  avmm_rr_arbiter dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .h_write              (h_write),
    .h_read               (h_read),
    .h_address            (h_address),
    .h_writedata          (h_writedata),
    .h_burstcount         (h_burstcount),
    .h_byteenable         (h_byteenable),
    .h_waitrequest        (h_waitrequest),
    .h_readdatavalid      (h_readdatavalid),
    .h_writeresponsevalid (h_writeresponsevalid),
    .h_readdata           (h_readdata),
    .d_write              (d_write),
    .d_read               (d_read),
    .d_address            (d_address),
    .d_writedata          (d_writedata),
    .d_burstcount         (d_burstcount),
    .d_byteenable         (d_byteenable),
    .d_waitrequest        (d_waitrequest),
    .d_readdatavalid      (d_readdatavalid),
    .d_writeresponsevalid (d_writeresponsevalid),
    .d_readdata           (d_readdata),
    .err_orphan           (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input int h, input logic [15:0] a, input logic [63:0] d);
    h_address[h*16 +: 16]   = a;
    h_writedata[h*64 +: 64] = d;
    h_burstcount[h]         = 1'b1;
    h_byteenable[h*8 +: 8]  = 8'hFF;
  endtask

  // Raise a command on host h, record its expected command and response, wait for acceptance.
  task automatic issue(input int h, input bit wr, input bit both,
                       input logic [15:0] a, input logic [63:0] d);
    cmd_t c;
    rsp_t r;
    bit   done;
    set_host(h, a, d);
    if (wr) h_write[h] = 1'b1;
    if (!wr || both) h_read[h] = 1'b1;
    c.wr = wr; c.addr = a; c.data = d;
    exp_cmd.push_back(c);
    r.vec = 2'b00;
    r.vec[h] = 1'b1;
    if (wr) begin
      r.data = 64'h0;
      exp_wrsp.push_back(r);
    end else begin
      r.data = 64'hA + 64'(issue_cnt);
      issue_cnt++;
      exp_rrsp.push_back(r);
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (!h_waitrequest[h]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    h_write[h] = 1'b0;
    h_read[h]  = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: host %0d got no acceptance want acceptance", h);
    end
  endtask

  task automatic respond_reads(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      d_readdatavalid = 1'b1;
      d_readdata      = 64'hA + 64'(resp_cnt);
      resp_cnt++;
    end
    tick();
    d_readdatavalid = 1'b0;
  endtask

  task automatic respond_writes(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      d_writeresponsevalid = 1'b1;
    end
    tick();
    d_writeresponsevalid = 1'b0;
  endtask

  // Monitor: compares every accepted sink command and every routed response.
  always @(negedge clk) begin
    cmd_t c;
    rsp_t r;
    if (rst_n && (d_write || d_read) && !d_waitrequest) begin
      acc_cnt++;
      if (exp_cmd.size() == 0) begin
        chk("cmd_unexpected", {d_write, d_read}, 64'h0);
      end else begin
        c = exp_cmd.pop_front();
        chk("cmd_type", {d_write, d_read}, {c.wr, ~c.wr});
        chk("cmd_addr", d_address, c.addr);
        chk("cmd_wdata", d_writedata, c.data);
      end
    end
    if (h_readdatavalid != 2'b00) begin
      if (exp_rrsp.size() == 0) begin
        chk("rdv_unexpected", h_readdatavalid, 64'h0);
      end else begin
        r = exp_rrsp.pop_front();
        chk("rdv_host", h_readdatavalid, r.vec);
        chk("rdv_data", h_readdata, r.data);
      end
    end
    if (h_writeresponsevalid != 2'b00) begin
      if (exp_wrsp.size() == 0) begin
        chk("wrv_unexpected", h_writeresponsevalid, 64'h0);
      end else begin
        r = exp_wrsp.pop_front();
        chk("wrv_host", h_writeresponsevalid, r.vec);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    rsp_t r;
    int   a0;
    rst_n = 1'b0;
    h_write = '0; h_read = '0; h_address = '0; h_writedata = '0;
    h_burstcount = '0; h_byteenable = '0;
    d_waitrequest = 1'b0; d_readdatavalid = 1'b0; d_writeresponsevalid = 1'b0;
    d_readdata = '0;

    // Reset state, with a request already pending
    h_read = 2'b01;
    @(negedge clk);
    chk("rst_wreq", h_waitrequest, 2'b11);
    chk("rst_rdv", h_readdatavalid, 2'b00);
    chk("rst_wrv", h_writeresponsevalid, 2'b00);
    chk("rst_cmd", {d_write, d_read}, 2'b00);
    chk("rst_orphan", err_orphan, 1'b0);
    tick();
    h_read = 2'b00;
    rst_n  = 1'b1;
    tick();

    // Both hosts write continuously: grants 0,1,0,1, one write every 2 cycles
    set_host(0, 16'h0100, 64'h1111);
    set_host(1, 16'h0200, 64'h2222);
    for (int i = 0; i < 4; i++) begin
      c.wr = 1'b1;
      c.addr = (i % 2 == 0) ? 16'h0100 : 16'h0200;
      c.data = (i % 2 == 0) ? 64'h1111 : 64'h2222;
      exp_cmd.push_back(c);
      r.vec = (i % 2 == 0) ? 2'b01 : 2'b10;
      r.data = 64'h0;
      exp_wrsp.push_back(r);
    end
    a0 = acc_cnt;
    h_write = 2'b11;
    repeat (8) tick();
    h_write = 2'b00;
    @(negedge clk);
    chk("rr_write_count", 64'(acc_cnt - a0), 64'd4);
    respond_writes(4);

    // Host0 two reads then host1 one read; data A,B,C returns to 0,0,1
    issue(0, 1'b0, 1'b0, 16'h00A0, 64'h0);
    issue(0, 1'b0, 1'b0, 16'h00A1, 64'h0);
    issue(1, 1'b0, 1'b0, 16'h00B0, 64'h0);
    respond_reads(3);

    // Host1 read of 0x10 held off by sink waitrequest for 3 cycles
    tick();
    set_host(1, 16'h0010, 64'h0);
    d_waitrequest = 1'b1;
    h_read[1] = 1'b1;
    c.wr = 1'b0; c.addr = 16'h0010; c.data = 64'h0;
    exp_cmd.push_back(c);
    r.vec = 2'b10; r.data = 64'hA + 64'(issue_cnt);
    issue_cnt++;
    exp_rrsp.push_back(r);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("wait_hwreq", h_waitrequest[1], 1'b1);
      chk("wait_dread", d_read, 1'b1);
      chk("wait_addr", d_address, 16'h0010);
    end
    tick();
    d_waitrequest = 1'b0;
    @(negedge clk);
    chk("accept_hwreq", h_waitrequest[1], 1'b0);
    chk("accept_dread", d_read, 1'b1);
    tick();
    h_read[1] = 1'b0;
    respond_reads(1);

    // Eight reads outstanding; the ninth stalls until a response is popped
    for (int i = 0; i < 8; i++) begin
      issue(i % 2, 1'b0, 1'b0, 16'h0300 + 16'(i), 64'h0);
    end
    set_host(1, 16'h03FF, 64'h0);
    h_read[1] = 1'b1;
    c.wr = 1'b0; c.addr = 16'h03FF; c.data = 64'h0;
    exp_cmd.push_back(c);
    r.vec = 2'b10; r.data = 64'hA + 64'(issue_cnt);
    issue_cnt++;
    exp_rrsp.push_back(r);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_dread", d_read, 1'b0);
      chk("full_hwreq", h_waitrequest[1], 1'b1);
      tick();
    end
    d_readdatavalid = 1'b1;
    d_readdata = 64'hA + 64'(resp_cnt);
    resp_cnt++;
    @(negedge clk);
    chk("samecyc_pop_dread", d_read, 1'b0);
    chk("samecyc_pop_hwreq", h_waitrequest[1], 1'b1);
    tick();
    d_readdatavalid = 1'b0;
    @(negedge clk);
    chk("unblock_dread", d_read, 1'b1);
    chk("unblock_hwreq", h_waitrequest[1], 1'b0);
    tick();
    h_read[1] = 1'b0;
    respond_reads(8);

    // Write and read both set on one host: write only
    issue(0, 1'b1, 1'b1, 16'h0700, 64'h7777);
    respond_writes(1);

    // Orphan read response
    @(negedge clk);
    chk("orphan_clear", err_orphan, 1'b0);
    tick();
    d_readdatavalid = 1'b1;
    d_readdata = 64'hBAD;
    @(negedge clk);
    chk("orphan_no_valid", h_readdatavalid, 2'b00);
    chk("orphan_not_yet", err_orphan, 1'b0);
    tick();
    d_readdatavalid = 1'b0;
    @(negedge clk);
    chk("orphan_set", err_orphan, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("orphan_sticky", err_orphan, 1'b1);

    // Reset with three reads outstanding discards their tags
    tick();
    issue(0, 1'b0, 1'b0, 16'h0800, 64'h0);
    issue(1, 1'b0, 1'b0, 16'h0801, 64'h0);
    issue(0, 1'b0, 1'b0, 16'h0802, 64'h0);
    rst_n = 1'b0;
    h_read = 2'b01;
    exp_rrsp.delete();
    resp_cnt = issue_cnt;
    @(negedge clk);
    chk("mid_rst_wreq", h_waitrequest, 2'b11);
    chk("mid_rst_dread", d_read, 1'b0);
    chk("mid_rst_orphan", err_orphan, 1'b0);
    tick();
    h_read = 2'b00;
    rst_n  = 1'b1;
    tick();
    d_readdatavalid = 1'b1;
    d_readdata = 64'hDEAD;
    @(negedge clk);
    chk("post_rst_no_valid", h_readdatavalid, 2'b00);
    tick();
    d_readdatavalid = 1'b0;
    @(negedge clk);
    chk("post_rst_orphan", err_orphan, 1'b1);

    tick();
    @(negedge clk);
    chk("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
    chk("rrsp_queue_empty", 64'(exp_rrsp.size()), 64'd0);
    chk("wrsp_queue_empty", 64'(exp_wrsp.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
